// File: rtl/urv_writeback_ahb.sv
// Writeback stage: finishes the AHB-Lite data phase for loads/stores, aligns load data, selects the result, writes the RF.
// Latency: register-file write lands one cycle after retire; a zero-wait load retires in its data-phase cycle.
// Backpressure: raises w_stall_req_o while a data phase has HREADY low; completions under w_stall_i are buffered in HOLD.
//
// Ports:
//   clk_i, rst_i                    pipeline clock, synchronous active-high reset
//   w_stall_i                       global stall, W must not retire this cycle
//   w_valid_i, w_load_i, w_store_i  instruction in W and its memory kind
//   w_fun_i                         funct3 load width/sign code
//   w_rd_i, w_rd_write_i            destination register and write intent
//   w_rd_value_i/_shifter_i/_multiply_i, w_rd_source_i   non-memory result candidates and selector
//   w_dm_addr_i                     data address of the access
//   HRDATA, HREADY, HRESP           AHB-Lite data-phase response
//   w_stall_req_o                   combinational stall request
//   rf_rd_o, rf_rd_value_o, rf_rd_write_o   registered register-file write port
//   w_bus_error_o, w_bus_error_addr_o       registered error pulse and faulting address
module urv_writeback_ahb #(
    parameter logic [31:0] LOAD_ERR_VALUE = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        w_stall_i,
    input  logic        w_valid_i,
    input  logic        w_load_i,
    input  logic        w_store_i,
    input  logic [2:0]  w_fun_i,
    input  logic [4:0]  w_rd_i,
    input  logic        w_rd_write_i,
    input  logic [31:0] w_rd_value_i,
    input  logic [31:0] w_rd_shifter_i,
    input  logic [31:0] w_rd_multiply_i,
    input  logic [1:0]  w_rd_source_i,
    input  logic [31:0] w_dm_addr_i,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic        HRESP,
    output logic        w_stall_req_o,
    output logic [4:0]  rf_rd_o,
    output logic [31:0] rf_rd_value_o,
    output logic        rf_rd_write_o,
    output logic        w_bus_error_o,
    output logic [31:0] w_bus_error_addr_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ERR,
        ST_HOLD
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] hold_q;

    logic        mem_op;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_aligned;
    logic [31:0] alu_result;

    logic        done;          // data phase finishes this cycle
    logic        done_err;      // ...and it finished with ERROR
    logic [31:0] done_value;
    logic        retire;
    logic [31:0] retire_value;
    logic        capture;

    assign mem_op = w_valid_i & (w_load_i | w_store_i);

    // Load lane extraction and extension
    always_comb begin
        load_byte    = HRDATA[7:0];
        load_half    = w_dm_addr_i[1] ? HRDATA[31:16] : HRDATA[15:0];
        load_aligned = HRDATA;
        case (w_dm_addr_i[1:0])
            2'd0:    load_byte = HRDATA[7:0];
            2'd1:    load_byte = HRDATA[15:8];
            2'd2:    load_byte = HRDATA[23:16];
            default: load_byte = HRDATA[31:24];
        endcase
        case (w_fun_i)
            3'b000:  load_aligned = {{24{load_byte[7]}}, load_byte};
            3'b001:  load_aligned = {{16{load_half[15]}}, load_half};
            3'b100:  load_aligned = {24'h0, load_byte};
            3'b101:  load_aligned = {16'h0, load_half};
            default: load_aligned = HRDATA;
        endcase
    end

    // Non-memory result; the reserved source code falls back to ALU/CSR
    always_comb begin
        case (w_rd_source_i)
            2'b01:   alu_result = w_rd_shifter_i;
            2'b10:   alu_result = w_rd_multiply_i;
            default: alu_result = w_rd_value_i;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        w_stall_req_o = 1'b0;
        done          = 1'b0;
        done_err      = 1'b0;
        retire        = 1'b0;
        retire_value  = alu_result;
        capture       = 1'b0;

        // Stall is only requested while HREADY is low; the completion cycle
        // itself must be free to retire.
        case (state_q)
            ST_IDLE: begin
                if (mem_op) begin
                    if (!HREADY) begin
                        w_stall_req_o = 1'b1;
                        state_d       = HRESP ? ST_ERR : ST_WAIT;
                    end else begin
                        // HRESP with HREADY in the first cycle is a protocol
                        // violation; treat it as an already-finished error.
                        done     = 1'b1;
                        done_err = HRESP;
                    end
                end else if (w_valid_i && !w_stall_i) begin
                    retire = 1'b1;
                end
            end
            ST_WAIT: begin
                if (!HREADY) begin
                    w_stall_req_o = 1'b1;
                    if (HRESP) state_d = ST_ERR;
                end else begin
                    done     = 1'b1;
                    done_err = HRESP;
                end
            end
            ST_ERR: begin
                if (!HREADY) begin
                    w_stall_req_o = 1'b1;
                end else begin
                    done     = 1'b1;
                    done_err = 1'b1;
                end
            end
            ST_HOLD: begin
                // HRDATA is stale here; the buffered value is authoritative.
                if (!w_stall_i) begin
                    retire       = 1'b1;
                    retire_value = hold_q;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        done_value = done_err ? LOAD_ERR_VALUE : load_aligned;

        if (done) begin
            if (w_stall_i) begin
                capture = 1'b1;
                state_d = ST_HOLD;
            end else begin
                retire       = 1'b1;
                retire_value = done_value;
                state_d      = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q            <= ST_IDLE;
            hold_q             <= 32'h0;
            rf_rd_o            <= 5'd0;
            rf_rd_value_o      <= 32'h0;
            rf_rd_write_o      <= 1'b0;
            w_bus_error_o      <= 1'b0;
            w_bus_error_addr_o <= 32'h0;
        end else begin
            state_q       <= state_d;
            rf_rd_write_o <= retire & w_rd_write_i & ~w_store_i & (w_rd_i != 5'd0);
            if (retire) begin
                rf_rd_o       <= w_rd_i;
                rf_rd_value_o <= retire_value;
            end
            if (capture) begin
                hold_q <= done_value;
            end
            w_bus_error_o <= done_err;
            if (done_err) begin
                w_bus_error_addr_o <= w_dm_addr_i;
            end
        end
    end

endmodule

// File: tb/tb_urv_writeback_ahb.sv
// Directed bench for urv_writeback_ahb: ALU writes, load alignment, wait states,
// stall buffering, bus errors and reset during a pending data phase.
module tb_urv_writeback_ahb;

    localparam logic [31:0] ERR_VAL = 32'hDEAD_0BAD;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        w_stall_i;
    logic        w_valid_i;
    logic        w_load_i;
    logic        w_store_i;
    logic [2:0]  w_fun_i;
    logic [4:0]  w_rd_i;
    logic        w_rd_write_i;
    logic [31:0] w_rd_value_i;
    logic [31:0] w_rd_shifter_i;
    logic [31:0] w_rd_multiply_i;
    logic [1:0]  w_rd_source_i;
    logic [31:0] w_dm_addr_i;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;
    logic        w_stall_req_o;
    logic [4:0]  rf_rd_o;
    logic [31:0] rf_rd_value_o;
    logic        rf_rd_write_o;
    logic        w_bus_error_o;
    logic [31:0] w_bus_error_addr_o;

    int n_checks = 0;
    int n_fail   = 0;

    urv_writeback_ahb #(.LOAD_ERR_VALUE(ERR_VAL)) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .w_stall_i         (w_stall_i),
        .w_valid_i         (w_valid_i),
        .w_load_i          (w_load_i),
        .w_store_i         (w_store_i),
        .w_fun_i           (w_fun_i),
        .w_rd_i            (w_rd_i),
        .w_rd_write_i      (w_rd_write_i),
        .w_rd_value_i      (w_rd_value_i),
        .w_rd_shifter_i    (w_rd_shifter_i),
        .w_rd_multiply_i   (w_rd_multiply_i),
        .w_rd_source_i     (w_rd_source_i),
        .w_dm_addr_i       (w_dm_addr_i),
        .HRDATA            (HRDATA),
        .HREADY            (HREADY),
        .HRESP             (HRESP),
        .w_stall_req_o     (w_stall_req_o),
        .rf_rd_o           (rf_rd_o),
        .rf_rd_value_o     (rf_rd_value_o),
        .rf_rd_write_o     (rf_rd_write_o),
        .w_bus_error_o     (w_bus_error_o),
        .w_bus_error_addr_o(w_bus_error_addr_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        w_stall_i       = 1'b0;
        w_valid_i       = 1'b0;
        w_load_i        = 1'b0;
        w_store_i       = 1'b0;
        w_fun_i         = 3'b010;
        w_rd_i          = 5'd0;
        w_rd_write_i    = 1'b0;
        w_rd_value_i    = 32'h0;
        w_rd_shifter_i  = 32'h0;
        w_rd_multiply_i = 32'h0;
        w_rd_source_i   = 2'b00;
        w_dm_addr_i     = 32'h0;
        HRDATA          = 32'h0;
        HREADY          = 1'b1;
        HRESP           = 1'b0;
    endtask

    task automatic load(input logic [2:0] fun, input logic [31:0] addr, input logic [4:0] rd);
        w_valid_i    = 1'b1;
        w_load_i     = 1'b1;
        w_store_i    = 1'b0;
        w_fun_i      = fun;
        w_dm_addr_i  = addr;
        w_rd_i       = rd;
        w_rd_write_i = 1'b1;
    endtask

    initial begin
        idle_inputs();
        rst_i = 1'b1;
        #1;
        cyc();
        cyc();
        rst_i = 1'b0;
        chk("rst_wr",     {31'h0, rf_rd_write_o}, 32'h0);
        chk("rst_rd",     {27'h0, rf_rd_o},       32'h0);
        chk("rst_val",    rf_rd_value_o,          32'h0);
        chk("rst_err",    {31'h0, w_bus_error_o}, 32'h0);
        chk("rst_eaddr",  w_bus_error_addr_o,     32'h0);
        chk("rst_stall",  {31'h0, w_stall_req_o}, 32'h0);

        // ALU / shifter / reserved-source writes
        w_valid_i = 1'b1; w_rd_write_i = 1'b1; w_rd_i = 5'd5;
        w_rd_value_i = 32'h1234; w_rd_shifter_i = 32'hDEAD_BEEF; w_rd_multiply_i = 32'h0BAD_F00D;
        cyc();
        chk("alu_wr",  {31'h0, rf_rd_write_o}, 32'h1);
        chk("alu_rd",  {27'h0, rf_rd_o},       32'd5);
        chk("alu_val", rf_rd_value_o,          32'h1234);
        w_rd_i = 5'd0;
        cyc();
        chk("x0_wr",   {31'h0, rf_rd_write_o}, 32'h0);
        w_rd_i = 5'd6; w_rd_source_i = 2'b01;
        cyc();
        chk("shf_val", rf_rd_value_o,          32'hDEAD_BEEF);
        w_rd_source_i = 2'b10;
        cyc();
        chk("mul_val", rf_rd_value_o,          32'h0BAD_F00D);
        w_rd_source_i = 2'b11;
        cyc();
        chk("rsv_val", rf_rd_value_o,          32'h1234);
        w_stall_i = 1'b1;
        cyc();
        chk("stl_wr",  {31'h0, rf_rd_write_o}, 32'h0);
        idle_inputs();
        cyc();
        chk("nv_wr",   {31'h0, rf_rd_write_o}, 32'h0);

        // Zero-wait load alignment
        HRDATA = 32'h80AA_BBCC;
        load(3'b000, 32'h0000_1003, 5'd7);
        #1;
        chk("lb_stall", {31'h0, w_stall_req_o}, 32'h0);
        cyc();
        chk("lb_wr",   {31'h0, rf_rd_write_o}, 32'h1);
        chk("lb_rd",   {27'h0, rf_rd_o},       32'd7);
        chk("lb_val",  rf_rd_value_o,          32'hFFFF_FF80);
        load(3'b100, 32'h0000_1003, 5'd7);
        cyc();
        chk("lbu_val", rf_rd_value_o,          32'h0000_0080);
        load(3'b001, 32'h0000_1002, 5'd7);
        cyc();
        chk("lh_val",  rf_rd_value_o,          32'hFFFF_80AA);
        load(3'b101, 32'h0000_1002, 5'd7);
        cyc();
        chk("lhu_val", rf_rd_value_o,          32'h0000_80AA);
        load(3'b000, 32'h0000_1001, 5'd7);
        cyc();
        chk("lb1_val", rf_rd_value_o,          32'hFFFF_FFBB);
        load(3'b010, 32'h0000_1000, 5'd7);
        cyc();
        chk("lw_val",  rf_rd_value_o,          32'h80AA_BBCC);

        // LW with three wait states
        load(3'b010, 32'h0000_2000, 5'd8);
        HREADY = 1'b0; HRDATA = 32'h5555_5555;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("ws_stall", {31'h0, w_stall_req_o}, 32'h1);
            cyc();
            chk("ws_nowr",  {31'h0, rf_rd_write_o}, 32'h0);
        end
        HREADY = 1'b1; HRDATA = 32'hCAFE_F00D;
        #1;
        chk("ws_done_stall", {31'h0, w_stall_req_o}, 32'h0);
        cyc();
        chk("ws_wr",   {31'h0, rf_rd_write_o}, 32'h1);
        chk("ws_val",  rf_rd_value_o,          32'hCAFE_F00D);
        idle_inputs();
        cyc();
        chk("ws_once", {31'h0, rf_rd_write_o}, 32'h0);

        // Completion under stall: buffered, written once after stall drops
        load(3'b010, 32'h0000_3000, 5'd9);
        HRDATA = 32'h1122_3344; w_stall_i = 1'b1;
        cyc();
        chk("hold_nowr1", {31'h0, rf_rd_write_o}, 32'h0);
        HRDATA = 32'h5566_7788;
        #1;
        chk("hold_stall", {31'h0, w_stall_req_o}, 32'h0);
        cyc();
        chk("hold_nowr2", {31'h0, rf_rd_write_o}, 32'h0);
        w_stall_i = 1'b0;
        cyc();
        chk("hold_wr",  {31'h0, rf_rd_write_o}, 32'h1);
        chk("hold_rd",  {27'h0, rf_rd_o},       32'd9);
        chk("hold_val", rf_rd_value_o,          32'h1122_3344);
        idle_inputs();
        cyc();
        chk("hold_once", {31'h0, rf_rd_write_o}, 32'h0);

        // Store bus error
        w_valid_i = 1'b1; w_store_i = 1'b1; w_rd_write_i = 1'b1; w_rd_i = 5'd4;
        w_dm_addr_i = 32'h4000_0010; HREADY = 1'b0; HRESP = 1'b1;
        #1;
        chk("serr_stall", {31'h0, w_stall_req_o}, 32'h1);
        cyc();
        chk("serr_nopulse", {31'h0, w_bus_error_o}, 32'h0);
        HREADY = 1'b1;
        cyc();
        chk("serr_pulse", {31'h0, w_bus_error_o}, 32'h1);
        chk("serr_addr",  w_bus_error_addr_o,     32'h4000_0010);
        chk("serr_nowr",  {31'h0, rf_rd_write_o}, 32'h0);
        idle_inputs();
        cyc();
        chk("serr_once",  {31'h0, w_bus_error_o}, 32'h0);

        // Load bus error writes the error value
        load(3'b010, 32'h4000_0020, 5'd10);
        HREADY = 1'b0; HRESP = 1'b1;
        cyc();
        HREADY = 1'b1; HRDATA = 32'h1357_9BDF;
        cyc();
        chk("lerr_pulse", {31'h0, w_bus_error_o}, 32'h1);
        chk("lerr_addr",  w_bus_error_addr_o,     32'h4000_0020);
        chk("lerr_wr",    {31'h0, rf_rd_write_o}, 32'h1);
        chk("lerr_val",   rf_rd_value_o,          ERR_VAL);
        idle_inputs();
        cyc();

        // Reset while a data phase is waiting
        load(3'b010, 32'h0000_5000, 5'd11);
        HREADY = 1'b0;
        cyc();
        rst_i = 1'b1;
        cyc();
        rst_i = 1'b0;
        w_valid_i = 1'b0; w_load_i = 1'b0;
        #1;
        chk("mrst_idle",  {31'h0, w_stall_req_o}, 32'h0);
        chk("mrst_wr",    {31'h0, rf_rd_write_o}, 32'h0);
        chk("mrst_rd",    {27'h0, rf_rd_o},       32'h0);
        chk("mrst_val",   rf_rd_value_o,          32'h0);
        chk("mrst_err",   {31'h0, w_bus_error_o}, 32'h0);
        chk("mrst_eaddr", w_bus_error_addr_o,     32'h0);
        load(3'b010, 32'h0000_6000, 5'd3);
        HREADY = 1'b1; HRDATA = 32'h0A0B_0C0D;
        cyc();
        chk("post_wr",  {31'h0, rf_rd_write_o}, 32'h1);
        chk("post_val", rf_rd_value_o,          32'h0A0B_0C0D);
        idle_inputs();
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/urv_writeback_ahb.md
# urv_writeback_ahb

Writeback stage of the Kamikaze-uRV pipeline, directly downstream of the execute stage. It consumes the X/W pipeline registers, completes the AHB-Lite data phase for loads and stores whose address phase execute issued, aligns and extends load data, and selects the result source. It drives a registered register-file write port, requests a pipeline stall while a data phase is pending, and reports bus errors.

## Interface
Parameters:
- LOAD_ERR_VALUE, 32'h0000_0000: value written to rd when a load ends with an ERROR response. The write happens only if rd ≠ x0.

Ports:
- clk_i  in  1  pipeline clock
- rst_i  in  1  synchronous, active-high reset
- w_stall_i  in  1  global stall; the W stage must not retire this cycle
- w_valid_i  in  1  instruction in W is valid
- w_load_i  in  1  instruction is a load whose address phase was issued last cycle
- w_store_i  in  1  instruction is a store whose address phase was issued last cycle
- w_fun_i  in  3  funct3 code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- w_rd_i  in  5  destination register
- w_rd_write_i  in  1  instruction writes rd
- w_rd_value_i  in  32  ALU/CSR result
- w_rd_shifter_i  in  32  shifter result
- w_rd_multiply_i  in  32  multiplier result
- w_rd_source_i  in  2  result source: 00 ALU/CSR, 01 shifter, 10 multiply, 11 reserved (treated as 00)
- w_dm_addr_i  in  32  data address of the load/store
- HRDATA  in  32  AHB read data
- HREADY  in  1  AHB transfer done
- HRESP  in  1  AHB response: 0 OKAY, 1 ERROR
- w_stall_req_o  out  1  combinational stall request to pipeline control
- rf_rd_o  out  5  register-file write index (registered)
- rf_rd_value_o  out  32  register-file write data (registered)
- rf_rd_write_o  out  1  register-file write enable (registered)
- w_bus_error_o  out  1  one-cycle pulse when a load/store ends with ERROR
- w_bus_error_addr_o  out  32  address of the last errored access (registered)

## Operation
- Memory instruction: w_valid_i & (w_load_i | w_store_i).
- FSM states:
  - IDLE: no data phase outstanding.
  - WAIT: data phase in progress, HREADY low.
  - ERR: first ERROR cycle seen (HRESP=1, HREADY=0).
  - HOLD: data phase has completed but w_stall_i was high, so the result is buffered.
- IDLE → WAIT when a memory instruction is present with HREADY=0 and HRESP=0.
- IDLE → ERR when a memory instruction is present with HREADY=0 and HRESP=1.
- IDLE/WAIT: on HREADY=1 with HRESP=0, the phase is complete.
  - If w_stall_i=0: retire, then go to IDLE.
  - If w_stall_i=1: capture the aligned load data into the hold register, then go to HOLD.
- WAIT → ERR on HRESP=1 with HREADY=0.
- ERR: the second cycle must be HREADY=1 with HRESP=1.
  - Pulse w_bus_error_o and latch w_dm_addr_i into w_bus_error_addr_o.
  - For loads, the write value is LOAD_ERR_VALUE.
  - Retire, or go to HOLD if w_stall_i=1.
- HOLD → IDLE on the first cycle with w_stall_i=0. The instruction retires using the held data. HRDATA is ignored in HOLD.
- Load alignment by w_dm_addr_i[1:0]:
  - B/BU: byte lane addr[1:0], sign- or zero-extended.
  - H/HU: half-word lane addr[1], extended the same way.
  - W: HRDATA unmodified.
  - Unaligned addresses are not checked here.
- Non-memory instruction retires when w_valid_i=1 and w_stall_i=0. The result is selected by w_rd_source_i.
- Retire write: rf_rd_write_o ← w_rd_write_i & !w_store_i & (w_rd_i≠0). rf_rd_o and rf_rd_value_o are updated on the same edge.
- w_stall_req_o = 1 in WAIT and ERR, and in IDLE when a memory instruction is present with HREADY=0. Otherwise 0; in particular it is 0 in HOLD.
- w_valid_i=0 in IDLE: no retire, and rf_rd_write_o ← 0.

## Timing
- Reset values: FSM IDLE, rf_rd_write_o=0, rf_rd_o=0, rf_rd_value_o=0, w_bus_error_o=0, w_bus_error_addr_o=0, hold register 0.
- Reset mid-transfer returns the FSM to IDLE with no write and no error pulse.
- Register-file write latency: one cycle after the retire cycle.
- A zero-wait load issued by execute in cycle N has its data phase in N+1, and rf_rd_write_o is high in N+2.
- Each HREADY-low cycle adds one cycle of latency.
- rf_rd_write_o is high for exactly one cycle per retired writing instruction.
- If w_stall_i and HREADY=1 occur together, the data is buffered (never lost) and the instruction retires exactly once.
- An ERROR response with HREADY=1 in its first cycle is a protocol violation. It is handled as the second ERR cycle.

## Test plan
- ALU write: w_valid_i=1, w_rd_source_i=00, w_rd_i=5, w_rd_value_i=32'h1234 → next cycle rf_rd_write_o=1, rf_rd_o=5, rf_rd_value_o=32'h1234. Repeat with w_rd_i=0 → rf_rd_write_o=0.
- LB, zero wait: addr=...3, HRDATA=32'h80AA_BBCC → value 32'hFFFF_FF80. LBU on the same data → 32'h0000_0080. LH at addr[1]=1 → 32'hFFFF_80AA.
- Wait states: LW with HREADY low for 3 cycles → w_stall_req_o=1 for exactly those 3 cycles; the write follows one cycle after HREADY=1 with value HRDATA.
- HOLD: HREADY=1 coincides with w_stall_i=1 for 2 cycles, and HRDATA changes afterwards → the written value equals HRDATA from the completion cycle, and there is a single write.
- Bus error: store to 32'h4000_0010 with response HRESP=1/HREADY=0 then HRESP=1/HREADY=1 → w_bus_error_o pulses once, w_bus_error_addr_o=32'h4000_0010, no register write. The same sequence for a load writes LOAD_ERR_VALUE.
- Reset asserted while in WAIT → FSM IDLE and all outputs at reset values on the next cycle. The next load completes normally.
